mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port of the RV32IM core between instruction fetch (IF) and
//  load/store (LS). One transaction in flight at a time. LS has fixed priority, and a
//  starvation counter bounds how long IF can wait. A timeout watchdog aborts a hung memory.
//  Sits between the core's IF/LS stages and the unified instruction/data memory.
// PARAMETERS
//  Size      32  data and address width in bits; byte-enable width is Size/8
//  MAX_WAIT  4   consecutive lost arbitrations after which IF is forced to win (>=1)
//  TIMEOUT   16  BUSY cycles without mem_ack before abort (>=2)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  if_req     in   1       IF read request; hold with if_addr stable until if_gnt
//  if_addr    in   Size    IF read address
//  if_gnt     out  1       one-cycle pulse: IF request accepted
//  if_rvalid  out  1       one-cycle pulse: IF transaction done; if_rdata valid
//  if_rdata   out  Size    read data (registered)
//  if_err     out  1       qualifies if_rvalid: transaction timed out
//  ls_req     in   1       LS request; hold with ls_* stable until ls_gnt
//  ls_we      in   1       1 = write, 0 = read
//  ls_addr    in   Size    LS address
//  ls_wdata   in   Size    write data
//  ls_be      in   Size/8  byte enables
//  ls_gnt     out  1       one-cycle pulse: LS request accepted
//  ls_rvalid  out  1       one-cycle pulse: LS done (read data or write completion)
//  ls_rdata   out  Size    read data; 0 on writes and on errors
//  ls_err     out  1       qualifies ls_rvalid: transaction timed out
//  mem_req    out  1       held high from grant until mem_ack or timeout
//  mem_we     out  1       latched write flag (0 for IF)
//  mem_addr   out  Size    latched address
//  mem_wdata  out  Size    latched write data (0 for IF)
//  mem_be     out  Size/8  latched byte enables (all ones for IF)
//  mem_ack    in   1       one-cycle completion from memory; valid only while mem_req=1
//  mem_rdata  in   Size    read data, valid with mem_ack
// BEHAVIOUR
//  - All outputs are registered. After reset, every output is 0, the FSM is IDLE and
//    wait_cnt = tmo_cnt = 0.
//  - FSM states: IDLE, BUSY_IF, BUSY_LS.
//  - IDLE: at each edge, sample the requests and pick a winner:
//    - ls_req wins, unless if_req=1 and wait_cnt==MAX_WAIT, in which case IF wins.
//    - On winning: latch the winner's fields into mem_*; go to BUSY_x. In the next cycle,
//      mem_req=1 and x_gnt=1 (one cycle only).
//    - No requests: stay in IDLE.
//  - wait_cnt:
//    - Increments, saturating at MAX_WAIT, on each IDLE edge where if_req=1 and LS wins.
//    - Clears when IF wins, or on an IDLE edge with if_req=0.
//  - BUSY_x: mem_req stays high and mem_* stay stable. tmo_cnt increments every cycle.
//    - mem_ack=1: capture mem_rdata (only for a read) and go to IDLE. In the next cycle,
//      x_rvalid=1 and x_err=0 for one cycle; mem_req=0.
//    - mem_ack=0 and tmo_cnt==TIMEOUT-1: abort and go to IDLE. In the next cycle,
//      x_rvalid=1, x_err=1, x_rdata=0, mem_req=0.
//    - mem_ack and timeout expiry in the same cycle: ack wins.
//  - Latency: request sampled at edge N -> gnt/mem_req in cycle N+1 -> earliest rvalid in
//    cycle N+2 (if mem_ack arrives in N+1) -> next grant can be sampled at the edge ending N+2.
//  - x_rdata holds its value until the next completion for that requester.
//  - mem_ack while mem_req=0: ignored.
//  - Requests are ignored while BUSY. A request dropped after being latched still completes.
//  - reset mid-transaction: next edge returns to IDLE, mem_req=0, and no rvalid is issued
//    for the aborted access.
// TESTING
//  1. Reset then idle: all outputs 0 over 10 cycles, mem_req never asserts.
//  2. IF alone, addr 0x100, mem_ack 1 cycle after mem_req, rdata 0x00500093 ->
//     if_gnt in cycle 1, if_rvalid in cycle 3 with if_rdata=0x00500093, if_err=0.
//  3. IF and LS request together, LS write 0x200 <= 0xDEADBEEF with be=4'b0011 ->
//     LS granted first; mem_we=1, mem_be=0011; ls_rvalid with ls_rdata=0; then IF granted.
//  4. Starvation: ls_req held continuously, if_req held, MAX_WAIT=4 ->
//     exactly 4 LS grants, then one IF grant, then LS resumes.
//  5. Timeout: grant, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles,
//     then rvalid+err with rdata=0; a late mem_ack is ignored.
//  6. reset pulsed in the 2nd BUSY cycle -> mem_req=0 next cycle, no rvalid,
//     wait_cnt cleared; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the memory port arbiter into one interface.
//   The sides are the instruction-fetch requester (if_*), the load/store
//   requester (ls_*) and the shared memory port (mem_*).
//   slave  : the arbiter's view. It samples the requests and mem_ack/mem_rdata,
//            and drives the grants, completions and mem_* fields.
//   master : the surrounding core and memory. This is the opposite direction.
//   Size   : data/address width; byte-enable width is Size/8.
interface mem_port_arbiter_if #(
   parameter int Size = 32
);
   // instruction fetch side
   logic              if_req;
   logic [Size-1:0]   if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [Size-1:0]   if_rdata;
   logic              if_err;

   // load/store side
   logic              ls_req;
   logic              ls_we;
   logic [Size-1:0]   ls_addr;
   logic [Size-1:0]   ls_wdata;
   logic [Size/8-1:0] ls_be;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [Size-1:0]   ls_rdata;
   logic              ls_err;

   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [Size-1:0]   mem_addr;
   logic [Size-1:0]   mem_wdata;
   logic [Size/8-1:0] mem_be;
   logic              mem_ack;
   logic [Size-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      output ls_gnt, ls_rvalid, ls_rdata, ls_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store (LS).
//   Only one transaction is in flight at a time. LS has fixed priority.
//   IF is forced through after MAX_WAIT consecutive lost arbitrations.
//   A watchdog aborts a transaction when TIMEOUT busy cycles pass without mem_ack.
//   Every output is a register.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave, which carries the if_*, ls_* and mem_* signals
// Parameters
//   Size (data/address width), MAX_WAIT (>=1), TIMEOUT (>=2)
module mem_port_arbiter #(
   parameter int Size     = 32,
   parameter int MAX_WAIT = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int BeW   = Size / 8;
   localparam int WaitW = $clog2(MAX_WAIT + 1);
   localparam int TmoW  = $clog2(TIMEOUT);

   localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
   localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

   // All registered outputs travel together so reset and hold are uniform.
   typedef struct packed {
      logic            if_gnt;
      logic            if_rvalid;
      logic [Size-1:0] if_rdata;
      logic            if_err;
      logic            ls_gnt;
      logic            ls_rvalid;
      logic [Size-1:0] ls_rdata;
      logic            ls_err;
      logic            mem_req;
      logic            mem_we;
      logic [Size-1:0] mem_addr;
      logic [Size-1:0] mem_wdata;
      logic [BeW-1:0]  mem_be;
   } out_t;

   state_t           state, state_n;
   logic [WaitW-1:0] wait_cnt, wait_n;
   logic [TmoW-1:0]  tmo_cnt, tmo_n;
   out_t             out_q, out_n;
   logic             if_forced;

   // IF overrides LS priority once it has lost MAX_WAIT arbitrations in a row.
   assign if_forced = bus.if_req && (wait_cnt == WaitMax);

   always_comb begin
      // NOTE: every signal gets a default before the case; a path that skipped an
      // assignment would otherwise infer a latch.
      state_n          = state;
      wait_n           = wait_cnt;
      tmo_n            = tmo_cnt;
      out_n            = out_q;      // mem_* fields and rdata hold by default
      out_n.if_gnt     = 1'b0;       // pulses default low
      out_n.ls_gnt     = 1'b0;
      out_n.if_rvalid  = 1'b0;
      out_n.ls_rvalid  = 1'b0;
      out_n.if_err     = 1'b0;
      out_n.ls_err     = 1'b0;

      unique case (state)
         IDLE: begin
            tmo_n = '0;
            if (bus.if_req && (!bus.ls_req || if_forced)) begin
               state_n         = BUSY_IF;
               wait_n          = '0;
               out_n.if_gnt    = 1'b1;
               out_n.mem_req   = 1'b1;
               out_n.mem_we    = 1'b0;
               out_n.mem_addr  = bus.if_addr;
               out_n.mem_wdata = '0;
               out_n.mem_be    = '1;
            end else if (bus.ls_req) begin
               state_n         = BUSY_LS;
               // IF lost this round only if it was asking; saturate at the limit.
               if (bus.if_req)
                  wait_n = (wait_cnt == WaitMax) ? wait_cnt : wait_cnt + WaitW'(1);
               else
                  wait_n = '0;
               out_n.ls_gnt    = 1'b1;
               out_n.mem_req   = 1'b1;
               out_n.mem_we    = bus.ls_we;
               out_n.mem_addr  = bus.ls_addr;
               out_n.mem_wdata = bus.ls_wdata;
               out_n.mem_be    = bus.ls_be;
            end else begin
               wait_n = '0;
            end
         end

         BUSY_IF, BUSY_LS: begin
            tmo_n = tmo_cnt + TmoW'(1);
            // Ack is checked first so it wins over a simultaneous timeout.
            if (bus.mem_ack) begin
               state_n       = IDLE;
               out_n.mem_req = 1'b0;
               if (state == BUSY_IF) begin
                  out_n.if_rvalid = 1'b1;
                  out_n.if_rdata  = bus.mem_rdata;
               end else begin
                  out_n.ls_rvalid = 1'b1;
                  out_n.ls_rdata  = out_q.mem_we ? '0 : bus.mem_rdata;
               end
            end else if (tmo_cnt == TmoLast) begin
               state_n       = IDLE;
               out_n.mem_req = 1'b0;
               if (state == BUSY_IF) begin
                  out_n.if_rvalid = 1'b1;
                  out_n.if_err    = 1'b1;
                  out_n.if_rdata  = '0;
               end else begin
                  out_n.ls_rvalid = 1'b1;
                  out_n.ls_err    = 1'b1;
                  out_n.ls_rdata  = '0;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         tmo_cnt  <= '0;
         out_q    <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
         tmo_cnt  <= tmo_n;
         out_q    <= out_n;
      end
   end

   assign bus.if_gnt    = out_q.if_gnt;
   assign bus.if_rvalid = out_q.if_rvalid;
   assign bus.if_rdata  = out_q.if_rdata;
   assign bus.if_err    = out_q.if_err;
   assign bus.ls_gnt    = out_q.ls_gnt;
   assign bus.ls_rvalid = out_q.ls_rvalid;
   assign bus.ls_rdata  = out_q.ls_rdata;
   assign bus.ls_err    = out_q.ls_err;
   assign bus.mem_req   = out_q.mem_req;
   assign bus.mem_we    = out_q.mem_we;
   assign bus.mem_addr  = out_q.mem_addr;
   assign bus.mem_wdata = out_q.mem_wdata;
   assign bus.mem_be    = out_q.mem_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed and randomized checks of mem_port_arbiter.
//   The reference model works at the level of arbitration rounds.
//   A round is either idle (no grant) or a grant, and the model keeps:
//     - a count of consecutive rounds that IF lost while it was asking
//     - the last completed read value for each requester
//   The bench itself acts as both requesters and the memory.
module tb_mem_port_arbiter;
   localparam int Size     = 32;
   localparam int MAX_WAIT = 4;
   localparam int TIMEOUT  = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.Size(Size)) bus ();

   mem_port_arbiter #(
      .Size(Size), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int          lost        = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_ls_rdata = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One edge while the arbiter is idle. The winner follows the priority rule,
   // and the resulting grant cycle is then checked.
   task automatic idle_edge(output int who);
      bit          ireq, lreq, we;
      logic [31:0] ia, la, wd;
      logic [3:0]  be;
      ireq = bus.if_req;  lreq = bus.ls_req;
      ia = bus.if_addr;   la = bus.ls_addr;  wd = bus.ls_wdata;
      be = bus.ls_be;     we = bus.ls_we;
      if (ireq && (!lreq || lost == MAX_WAIT)) who = 1;
      else if (lreq)                           who = 2;
      else                                     who = 0;
      if (who == 2 && ireq) lost = (lost < MAX_WAIT) ? lost + 1 : MAX_WAIT;
      else                  lost = 0;
      step();
      check("gnt", {bus.if_gnt, bus.ls_gnt}, {who == 1, who == 2});
      check("grant_mem_req", bus.mem_req, who != 0);
      check("idle_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
      if (who == 1)
         check("if_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be},
               {1'b0, ia, 32'h0, 4'hF});
      else if (who == 2)
         check("ls_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be},
               {we, la, wd, be});
   endtask

   // Runs the memory side of a granted transaction.
   // Called in the grant cycle. d is the number of busy cycles before mem_ack;
   // a negative d means the memory never answers.
   task automatic busy_phase(input int who, input int d, input logic [31:0] rd, input bit we);
      bit          acked = 1'b0;
      logic [31:0] exp_rd;
      for (int k = 0; k < TIMEOUT; k++) begin
         check("busy_mem_req", bus.mem_req, 1'b1);
         check("busy_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
         if (k > 0) check("busy_gnt", {bus.if_gnt, bus.ls_gnt}, 2'b00);
         if (k == d) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            step();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            acked = 1'b1;
            break;
         end
         step();
      end
      exp_rd = (acked && !(who == 2 && we)) ? rd : 32'h0;
      if (who == 1) exp_if_rdata = exp_rd;
      else          exp_ls_rdata = exp_rd;
      check("done_mem_req", bus.mem_req, 1'b0);
      check("done_rvalid", {bus.if_rvalid, bus.ls_rvalid}, {who == 1, who == 2});
      check("done_err", {bus.if_err, bus.ls_err}, {who == 1 && !acked, who == 2 && !acked});
      check("if_rdata", bus.if_rdata, exp_if_rdata);
      check("ls_rdata", bus.ls_rdata, exp_ls_rdata);
   endtask

   initial begin
      int          who;
      int          seq[10];
      int          exp_seq[10];
      bit          if_pend, ls_pend, ls_we_save;
      int          d;

      exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      bus.if_req = 0; bus.if_addr = '0;
      bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_be = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      step();
      step();

      // reset values, then idle with nothing requesting
      check("rst_flags", {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.ls_gnt, bus.ls_rvalid,
                          bus.ls_err, bus.mem_req, bus.mem_we, bus.mem_be}, '0);
      check("rst_rdata", {bus.if_rdata, bus.ls_rdata}, '0);
      check("rst_mem", {bus.mem_addr, bus.mem_wdata}, '0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         idle_edge(who);
         check("idle_who", who, 0);
      end

      // IF alone: the response 0x00500093 arrives one cycle after mem_req
      bus.if_req = 1; bus.if_addr = 32'h100;
      idle_edge(who);
      check("t2_who", who, 1);
      bus.if_req = 0;
      busy_phase(1, 1, 32'h00500093, 1'b0);
      check("t2_rdata", bus.if_rdata, 32'h00500093);

      // simultaneous requests: the LS write goes first, then IF
      bus.if_req = 1; bus.if_addr = 32'h104;
      bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h200;
      bus.ls_wdata = 32'hDEADBEEF; bus.ls_be = 4'b0011;
      idle_edge(who);
      check("t3_first", who, 2);
      bus.ls_req = 0;
      busy_phase(2, 2, 32'h12345678, 1'b1);
      check("t3_ls_rdata", bus.ls_rdata, 32'h0);
      idle_edge(who);
      check("t3_second", who, 1);
      bus.if_req = 0;
      busy_phase(1, 0, 32'hCAFE0001, 1'b0);

      // starvation: both requests held, LS is a read
      bus.if_req = 1; bus.if_addr = 32'h300;
      bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h400; bus.ls_be = 4'hF;
      for (int r = 0; r < 10; r++) begin
         idle_edge(who);
         seq[r] = who;
         busy_phase(who, r % 3, $urandom, 1'b0);
      end
      for (int r = 0; r < 10; r++) check($sformatf("t4_seq%0d", r), seq[r], exp_seq[r]);
      bus.if_req = 0; bus.ls_req = 0;

      // timeout: no mem_ack, then a late mem_ack must be ignored
      bus.if_req = 1; bus.if_addr = 32'h500;
      idle_edge(who);
      bus.if_req = 0;
      busy_phase(1, -1, 32'h0, 1'b0);
      check("t5_err_rdata", bus.if_rdata, 32'h0);
      bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0BAD0;
      idle_edge(who);
      bus.mem_ack = 0;
      check("t5_late_ack", {bus.if_rvalid, bus.ls_rvalid, bus.mem_req}, 3'b000);

      // reset in the second busy cycle, with IF's lost count at its limit
      bus.if_req = 1; bus.ls_req = 1; bus.ls_we = 0;
      for (int r = 0; r < 3; r++) begin
         idle_edge(who);
         busy_phase(who, 0, $urandom, 1'b0);
      end
      idle_edge(who);
      check("t6_pre", who, 2);
      step();
      check("t6_busy1", bus.mem_req, 1'b1);
      bus.if_req = 0; bus.ls_req = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      lost = 0; exp_if_rdata = '0; exp_ls_rdata = '0;
      check("t6_mem_req", bus.mem_req, 1'b0);
      check("t6_outs", {bus.if_rvalid, bus.ls_rvalid, bus.if_gnt, bus.ls_gnt}, 4'b0000);
      check("t6_rdata", {bus.if_rdata, bus.ls_rdata}, '0);
      idle_edge(who);
      bus.if_req = 1; bus.ls_req = 1;
      idle_edge(who);
      check("t6_after", who, 2);
      bus.ls_req = 0; bus.if_req = 0;
      busy_phase(2, 1, 32'h0BADF00D, 1'b0);

      // randomized rounds
      if_pend = 0; ls_pend = 0; ls_we_save = 0;
      for (int r = 0; r < 150; r++) begin
         if (!if_pend && $urandom_range(0, 1) == 1) begin
            bus.if_req = 1; bus.if_addr = $urandom & 32'hFFFF_FFFC; if_pend = 1;
         end
         if (!ls_pend && $urandom_range(0, 1) == 1) begin
            bus.ls_req = 1; bus.ls_we = $urandom_range(0, 1) == 1;
            bus.ls_addr = $urandom; bus.ls_wdata = $urandom; bus.ls_be = 4'($urandom);
            ls_pend = 1;
         end
         ls_we_save = bus.ls_we;
         idle_edge(who);
         d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
         if (who == 1) begin
            bus.if_req = 0; if_pend = 0;
            busy_phase(1, d, $urandom, 1'b0);
         end else if (who == 2) begin
            bus.ls_req = 0; ls_pend = 0;
            busy_phase(2, d, $urandom, ls_we_save);
         end
      end
      bus.if_req = 0; bus.ls_req = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
